// File: rtl/core_mem.sv
// Core memory bank on the membus: MC request decode, ack/restart, core cycle timing.
// Optional feature macro: CORE_DESTRUCTIVE_RD_EN (destructive core read).
module core_mem #(
    parameter int         ADDR_BITS = 14,
    parameter logic [3:0] SEL       = 4'h0,
    parameter int         ACK_DLY   = 2,
    parameter int         RD_DLY    = 4,
    parameter int         RS_LEN    = 2,
    parameter int         WR_DLY    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        membus_mc_rq_cyc,
    input  logic        membus_mc_rd_rq,
    input  logic        membus_mc_wr_rq,
    input  logic        membus_mc_wr_rs,
    input  logic [14:0] membus_ma,
    input  logic [3:0]  membus_sel,
    input  logic        membus_fmc_select,
    input  logic [35:0] membus_mb_write,
    output logic        membus_mai_cmc_addr_ack,
    output logic        membus_mai_cmc_rd_rs,
    output logic [35:0] membus_mb_read
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_ACKH,
        S_RD,
        S_RS,
        S_WAITW,
        S_WR,
        S_RESTORE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [ADDR_BITS-1:0]   addr;
    logic                   rd_f;
    logic                   wr_f;
    logic [35:0]            rbuf;
    logic [35:0]            wbuf;
    logic [35:0]            mem [2**ADDR_BITS];

    logic                   hi_zero;
    logic                   sel_hit;
    logic                   last;
    logic                   mem_we;
    logic [35:0]            mem_wd;

    // Bits of ma above the bank's word range must be zero for a hit.
    assign hi_zero = (membus_ma >> ADDR_BITS) == 15'd0;

    assign sel_hit = membus_mc_rq_cyc
                   & (membus_mc_rd_rq | membus_mc_wr_rq)
                   & (membus_sel == SEL)
                   & ~membus_fmc_select
                   & hi_zero;

    // Each timed state is loaded with its length and exits on the cycle cnt==1.
    assign last = (cnt == CW'(1));

    // Ack tracks rq_cyc combinationally so it drops in the same cycle MC does.
    assign membus_mai_cmc_addr_ack = (state == S_ACKH) & membus_mc_rq_cyc;
    assign membus_mai_cmc_rd_rs    = (state == S_RS);
    assign membus_mb_read          = membus_mai_cmc_rd_rs ? rbuf : 36'd0;

    // Array write port: end of WR, end of RESTORE, and optional destructive read.
    always_comb begin
        mem_we = 1'b0;
        mem_wd = rbuf;
        if (reset_n) begin
            unique case (state)
                S_WR: begin
                    mem_we = last;
                    mem_wd = wbuf | membus_mb_write;
                end
                S_RESTORE: begin
                    mem_we = last;
                    mem_wd = rbuf;
                end
`ifdef CORE_DESTRUCTIVE_RD_EN
                S_RD: begin
                    mem_we = last;
                    mem_wd = 36'd0;
                end
`endif
                default: ;
            endcase
        end
    end

    // Core array storage; intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr] <= mem_wd;
    end

    // Core cycle sequencer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            addr  <= '0;
            rd_f  <= 1'b0;
            wr_f  <= 1'b0;
            rbuf  <= '0;
            wbuf  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (sel_hit) begin
                        addr  <= membus_ma[ADDR_BITS-1:0];
                        rd_f  <= membus_mc_rd_rq;
                        wr_f  <= membus_mc_wr_rq;
                        cnt   <= CW'(ACK_DLY);
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!membus_mc_rq_cyc)
                        state <= S_IDLE;
                    else if (last)
                        state <= S_ACKH;
                    else
                        cnt <= cnt - 1'b1;
                end
                S_ACKH: begin
                    if (!membus_mc_rq_cyc) begin
                        if (rd_f) begin
                            state <= S_RD;
                            cnt   <= CW'(RD_DLY);
                        end else begin
                            state <= S_WAITW;
                        end
                    end
                end
                S_RD: begin
                    if (last) begin
                        rbuf  <= mem[addr];
                        state <= S_RS;
                        cnt   <= CW'(RS_LEN);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RS: begin
                    if (last) begin
                        if (wr_f) begin
                            state <= S_WAITW;
                        end else begin
                            state <= S_RESTORE;
                            cnt   <= CW'(WR_DLY);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAITW: begin
                    if (membus_mc_wr_rs) begin
                        wbuf  <= '0;
                        state <= S_WR;
                        cnt   <= CW'(WR_DLY);
                    end
                end
                S_WR: begin
                    wbuf <= wbuf | membus_mb_write;
                    if (last)
                        state <= S_IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                S_RESTORE: begin
                    if (last)
                        state <= S_IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem.sv
// Directed bench for core_mem: read, write, RMW, deselect, abort, reset.
// Build with CORE_DESTRUCTIVE_RD_EN to check the destructive-read variant.
module tb_core_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rq_cyc;
    logic        rd_rq;
    logic        wr_rq;
    logic        wr_rs;
    logic [14:0] ma;
    logic [3:0]  sel;
    logic        fmc;
    logic [35:0] mb_write;
    logic        addr_ack;
    logic        rd_rs;
    logic [35:0] mb_read;

    int total = 0;
    int bad   = 0;
    int rs_seen = 0;

    core_mem dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .membus_mc_rq_cyc        (rq_cyc),
        .membus_mc_rd_rq         (rd_rq),
        .membus_mc_wr_rq         (wr_rq),
        .membus_mc_wr_rs         (wr_rs),
        .membus_ma               (ma),
        .membus_sel              (sel),
        .membus_fmc_select       (fmc),
        .membus_mb_write         (mb_write),
        .membus_mai_cmc_addr_ack (addr_ack),
        .membus_mai_cmc_rd_rs    (rd_rs),
        .membus_mb_read          (mb_read)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rd_rs === 1'b1)
            rs_seen <= rs_seen + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
        end
    endtask

    // One MC cycle. rd/wr select read, write or RMW; d0/d1 are the two
    // data beats driven after wr_rs. Ack and restart timing checked here.
    task automatic do_cycle(input logic [14:0] a, input logic rd,
                            input logic wr, input logic [35:0] d0,
                            input logic [35:0] d1,
                            output logic [35:0] rdata);
        int lat;
        int rs_len;
        ma    = a;
        rd_rq = rd;
        wr_rq = wr;
        rq_cyc = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!addr_ack && lat < 20);
        chk("ack_lat", lat, 3);
        chk("rd_idle_zero", mb_read, 0);
        @(negedge clk);
        rq_cyc = 1'b0;
        rd_rq  = 1'b0;
        wr_rq  = 1'b0;
        #1;
        chk("ack_drop", addr_ack, 0);
        rdata = '0;
        if (rd) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!rd_rs && lat < 30);
            chk("rs_lat", lat, 5);
            rs_len = 0;
            while (rd_rs && rs_len < 10) begin
                rdata = mb_read;
                rs_len++;
                @(negedge clk);
            end
            chk("rs_len", rs_len, 2);
        end
        if (wr) begin
            repeat (2) @(negedge clk);
            wr_rs = 1'b1;
            @(negedge clk);
            wr_rs    = 1'b0;
            mb_write = d0;
            @(negedge clk);
            mb_write = d1;
            @(negedge clk);
            mb_write = '0;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic deselect(input string tag, input logic [3:0] s,
                            input logic f, input logic [14:0] a);
        int n;
        n = 0;
        sel = s;
        fmc = f;
        ma  = a;
        rd_rq  = 1'b1;
        wr_rq  = 1'b1;
        rq_cyc = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (addr_ack) n++;
        end
        rq_cyc = 1'b0;
        rd_rq  = 1'b0;
        wr_rq  = 1'b0;
        sel = 4'h0;
        fmc = 1'b0;
        repeat (2) @(negedge clk);
        chk(tag, n, 0);
    endtask

    initial begin
        logic [35:0] d;
        logic [35:0] keep;
        int rs0;
        int lat;
        reset_n  = 1'b0;
        rq_cyc   = 1'b0;
        rd_rq    = 1'b0;
        wr_rq    = 1'b0;
        wr_rs    = 1'b0;
        ma       = '0;
        sel      = 4'h0;
        fmc      = 1'b0;
        mb_write = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", addr_ack, 0);
        chk("rst_rs", rd_rs, 0);
        chk("rst_data", mb_read, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // T1: load 0o1234, read it twice (restore keeps it)
        do_cycle(15'o1234, 1'b0, 1'b1, 36'o123456701234, 36'o0, d);
        do_cycle(15'o1234, 1'b1, 1'b0, 36'o0, 36'o0, d);
        chk("t1_read", d, 36'o123456701234);
        do_cycle(15'o1234, 1'b1, 1'b0, 36'o0, 36'o0, d);
        chk("t1_restore", d, 36'o123456701234);

        // T2: write-only, data held two beats, no rd_rs
        rs0 = rs_seen;
        do_cycle(15'o17, 1'b0, 1'b1, 36'o777000000777,
                 36'o777000000777, d);
        chk("t2_no_rs", rs_seen - rs0, 0);
        do_cycle(15'o17, 1'b1, 1'b0, 36'o0, 36'o0, d);
        chk("t2_read", d, 36'o777000000777);

        // Write data beats are OR-accumulated
        do_cycle(15'o20, 1'b0, 1'b1, 36'o000000000077,
                 36'o770000000000, d);
        do_cycle(15'o20, 1'b1, 1'b0, 36'o0, 36'o0, d);
        chk("or_acc", d, 36'o770000000077);

        // Top word of the bank
        do_cycle(15'o37777, 1'b0, 1'b1, 36'o555555555555, 36'o0, d);
        do_cycle(15'o37777, 1'b1, 1'b0, 36'o0, 36'o0, d);
        chk("top_addr", d, 36'o555555555555);

        // T3: RMW returns old word, stores new one
        do_cycle(15'o5, 1'b0, 1'b1, 36'o1, 36'o0, d);
        do_cycle(15'o5, 1'b1, 1'b1, 36'o2, 36'o0, d);
        chk("t3_rmw_old", d, 36'o1);
        do_cycle(15'o5, 1'b1, 1'b0, 36'o0, 36'o0, d);
        chk("t3_rmw_new", d, 36'o2);

        // T4: deselected requests never acked, memory untouched
        deselect("t4_sel", 4'h1, 1'b0, 15'o1234);
        deselect("t4_fmc", 4'h0, 1'b1, 15'o1234);
        deselect("t4_hiaddr", 4'h0, 1'b0, 15'o41234);
        do_cycle(15'o1234, 1'b1, 1'b0, 36'o0, 36'o0, d);
        chk("t4_unchanged", d, 36'o123456701234);

        // T5: abort one cycle after accept, then immediate new request
        ma     = 15'o20;
        rd_rq  = 1'b1;
        rq_cyc = 1'b1;
        @(negedge clk);
        rq_cyc = 1'b0;
        rd_rq  = 1'b0;
        @(negedge clk);
        chk("t5_no_ack", addr_ack, 0);
        do_cycle(15'o20, 1'b1, 1'b0, 36'o0, 36'o0, d);
        chk("t5_reacc", d, 36'o770000000077);

        // T6: reset while waiting for write data in an RMW
        do_cycle(15'o5, 1'b0, 1'b1, 36'o1, 36'o0, d);
        ma     = 15'o5;
        rd_rq  = 1'b1;
        wr_rq  = 1'b1;
        rq_cyc = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!addr_ack && lat < 20);
        @(negedge clk);
        rq_cyc = 1'b0;
        rd_rq  = 1'b0;
        wr_rq  = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rd_rs && lat < 30);
        lat = 0;
        while (rd_rs && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("t6_rs_seen", lat, 2);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_ack", addr_ack, 0);
        chk("t6_rs", rd_rs, 0);
        chk("t6_data", mb_read, 0);
        reset_n = 1'b1;
        @(negedge clk);
`ifdef CORE_DESTRUCTIVE_RD_EN
        keep = 36'o0;
`else
        keep = 36'o1;
`endif
        do_cycle(15'o5, 1'b1, 1'b0, 36'o0, 36'o0, d);
        chk("t6_word", d, keep);

        // Reset while rd_rs is driving the bus
        ma     = 15'o17;
        rd_rq  = 1'b1;
        rq_cyc = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!addr_ack && lat < 20);
        @(negedge clk);
        rq_cyc = 1'b0;
        rd_rq  = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rd_rs && lat < 30);
        chk("rsrst_pre", mb_read, 36'o777000000777);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rsrst_rs", rd_rs, 0);
        chk("rsrst_data", mb_read, 0);
        reset_n = 1'b1;
        @(negedge clk);
`ifdef CORE_DESTRUCTIVE_RD_EN
        keep = 36'o0;
`else
        keep = 36'o777000000777;
`endif
        do_cycle(15'o17, 1'b1, 1'b0, 36'o0, 36'o0, d);
        chk("rsrst_word", d, keep);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
